// File: rtl/val2_pkg.sv
// Shared types for the pipelined operand-2 generator: shift/mode encodings and
// the decoded request held in the first pipeline stage.
package val2_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        MODE_MEM,
        MODE_IMM,
        MODE_SHIFT_IMM,
        MODE_SHIFT_REG
    } mode_t;

    // amt is the amount modulo DATA_W; full/over flag amounts equal to / above DATA_W
    // (for ROR, full means a non-zero multiple of DATA_W).
    typedef struct packed {
        mode_t      mode;
        shift_t     typ;
        logic [7:0] amt;
        logic       passthru;
        logic       rrx;
        logic       full;
        logic       over;
        logic       carry_in;
    } s1_payload_t;

endpackage

// File: rtl/val2_pipe_shifter_if.sv
// Request/response bundle of the operand-2 generator; slave side is the shifter.
interface val2_pipe_shifter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [11:0]       shift_operand;
    logic [DATA_W-1:0] rm_value;
    logic [7:0]        rs_value;
    logic              imm;
    logic              mem;
    logic              reg_shift;
    logic              carry_in;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] val2;
    logic              carry_out;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, shift_operand, rm_value, rs_value, imm, mem, reg_shift,
               carry_in, in_tag, out_ready,
        output in_ready, out_valid, val2, carry_out, out_tag
    );

    modport master (
        output in_valid, shift_operand, rm_value, rs_value, imm, mem, reg_shift,
               carry_in, in_tag, out_ready,
        input  in_ready, out_valid, val2, carry_out, out_tag
    );
endinterface

// File: rtl/val2_shift_core.sv
// Combinational barrel shifter/rotator working on the pre-decoded stage-1 payload.
module val2_shift_core
    import val2_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rm,
    input  s1_payload_t       ctl,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    int unsigned              amt_i;
    logic [DATA_W-1:0]        spill;
    logic signed [DATA_W-1:0] rm_s;

    always_comb begin
        result = rm;
        carry  = ctl.carry_in;
        amt_i  = 32'(ctl.amt);
        spill  = '0;
        rm_s   = rm;
        if (ctl.mode == MODE_MEM || ctl.passthru) begin
            result = rm;
        end else if (ctl.rrx) begin
            result = {ctl.carry_in, rm[DATA_W-1:1]};
            carry  = rm[0];
        end else if (ctl.full || ctl.over) begin
            case (ctl.typ)
                SH_LSL: begin
                    result = '0;
                    carry  = ctl.full & rm[0];
                end
                SH_LSR: begin
                    result = '0;
                    carry  = ctl.full & rm[DATA_W-1];
                end
                SH_ASR: begin
                    result = {DATA_W{rm[DATA_W-1]}};
                    carry  = rm[DATA_W-1];
                end
                SH_ROR: begin
                    result = rm;
                    carry  = rm[DATA_W-1];
                end
            endcase
        end else begin
            // Carry is the last bit shifted out, picked by a second shift.
            case (ctl.typ)
                SH_LSL: begin
                    result = rm << amt_i;
                    spill  = rm >> (DATA_W - amt_i);
                    carry  = spill[0];
                end
                SH_LSR: begin
                    result = rm >> amt_i;
                    spill  = rm >> (amt_i - 1);
                    carry  = spill[0];
                end
                SH_ASR: begin
                    result = rm_s >>> amt_i;
                    spill  = rm >> (amt_i - 1);
                    carry  = spill[0];
                end
                SH_ROR: begin
                    result = (rm >> amt_i) | (rm << (DATA_W - amt_i));
                    carry  = result[DATA_W-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/val2_pipe_shifter.sv
// Two-stage operand-2 generator: S1 holds the decoded request, S2 the shifted
// result; valid/ready flow control with in-order tags and synchronous flush.
module val2_pipe_shifter
    import val2_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    val2_pipe_shifter_if.slave bus
);

    localparam int unsigned AMT_MASK = DATA_W - 1;

    logic              s1_valid_q, s1_valid_d;
    s1_payload_t       s1_ctl_q, s1_ctl_d;
    logic [DATA_W-1:0] s1_opnd_q, s1_opnd_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] val2_q, val2_d;
    logic              carry_q, carry_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    s1_payload_t       dec;
    logic [DATA_W-1:0] opnd_dec;
    int unsigned       n_i;
    shift_t            typ_in;
    logic              s2_adv;
    logic              in_ready;
    logic              accept;
    logic [DATA_W-1:0] core_res;
    logic              core_carry;

    // Every mode is reduced to an operand plus a shift request so the core stays uniform.
    always_comb begin
        dec          = '0;
        dec.carry_in = bus.carry_in;
        opnd_dec     = bus.rm_value;
        typ_in       = shift_t'(bus.shift_operand[6:5]);
        n_i          = 0;
        if (bus.mem) begin
            dec.mode = MODE_MEM;
            opnd_dec = {{(DATA_W-12){bus.shift_operand[11]}}, bus.shift_operand};
        end else if (bus.imm) begin
            dec.mode     = MODE_IMM;
            dec.typ      = SH_ROR;
            opnd_dec     = {{(DATA_W-8){1'b0}}, bus.shift_operand[7:0]};
            n_i          = 2 * 32'(bus.shift_operand[11:8]);
            dec.passthru = (n_i == 0);
        end else if (bus.reg_shift) begin
            dec.mode     = MODE_SHIFT_REG;
            dec.typ      = typ_in;
            n_i          = 32'(bus.rs_value);
            dec.passthru = (n_i == 0);
        end else begin
            dec.mode = MODE_SHIFT_IMM;
            dec.typ  = typ_in;
            n_i      = 32'(bus.shift_operand[11:7]);
            if (n_i == 0) begin
                case (typ_in)
                    SH_LSL:  dec.passthru = 1'b1;
                    SH_ROR:  dec.rrx      = 1'b1;
                    default: n_i          = DATA_W;
                endcase
            end
        end
        if (dec.typ == SH_ROR) begin
            dec.full = (n_i != 0) && ((n_i & AMT_MASK) == 0);
        end else begin
            dec.full = (n_i == DATA_W);
            dec.over = (n_i > DATA_W);
        end
        dec.amt = 8'(n_i & AMT_MASK);
    end

    val2_shift_core #(.DATA_W(DATA_W)) u_core (
        .rm     (s1_opnd_q),
        .ctl    (s1_ctl_q),
        .result (core_res),
        .carry  (core_carry)
    );

    always_comb begin
        s2_adv      = !out_valid_q || bus.out_ready;
        in_ready    = !flush && (!s1_valid_q || s2_adv);
        accept      = bus.in_valid && in_ready;
        s1_valid_d  = s1_valid_q;
        s1_ctl_d    = s1_ctl_q;
        s1_opnd_d   = s1_opnd_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        val2_d      = val2_q;
        carry_d     = carry_q;
        tag_d       = tag_q;

        if (flush)       s1_valid_d = 1'b0;
        else if (accept) s1_valid_d = 1'b1;
        else if (s2_adv) s1_valid_d = 1'b0;

        if (accept) begin
            s1_ctl_d  = dec;
            s1_opnd_d = opnd_dec;
            s1_tag_d  = bus.in_tag;
        end

        if (flush)       out_valid_d = 1'b0;
        else if (s2_adv) out_valid_d = s1_valid_q;

        if (!flush && s2_adv && s1_valid_q) begin
            val2_d  = core_res;
            carry_d = core_carry;
            tag_d   = s1_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ctl_q    <= '0;
            s1_opnd_q   <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            val2_q      <= '0;
            carry_q     <= 1'b0;
            tag_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ctl_q    <= s1_ctl_d;
            s1_opnd_q   <= s1_opnd_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            val2_q      <= val2_d;
            carry_q     <= carry_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.val2      = val2_q;
    assign bus.carry_out = carry_q;
    assign bus.out_tag   = tag_q;

endmodule

// File: tb/tb_val2_pipe_shifter.sv
// Self-checking bench for val2_pipe_shifter: queue-based behavioural model,
// per-cycle compare of handshake and data, directed corner cases plus random traffic.
`timescale 1ns/1ps
module tb_val2_pipe_shifter;

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    val2_pipe_shifter_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

    val2_pipe_shifter #(.DATA_W(DW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] so;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic        imm;
        logic        mem;
        logic        rsh;
        logic        cin;
        logic [3:0]  tag;
    } req_t;

    typedef struct {
        logic [31:0] v;
        logic        c;
        logic [3:0]  tag;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc      = 0;
    int          n_cmp    = 0;
    int          n_bad    = 0;
    logic        rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: ARM-style operand-2 rules evaluated with wide arithmetic.
    function automatic logic [32:0] model(input req_t r);
        logic [31:0]        v;
        logic               c;
        logic [31:0]        x;
        logic [63:0]        w;
        logic signed [63:0] sw;
        int unsigned        n;
        int unsigned        m;
        logic [1:0]         ty;
        ty = r.so[6:5];
        v  = r.rm;
        c  = r.cin;
        if (r.mem) return {r.cin, {{20{r.so[11]}}, r.so}};
        if (r.imm) begin
            x = {24'h0, r.so[7:0]};
            n = 2 * int'(r.so[11:8]);
            if (n == 0) return {r.cin, x};
            v = (x >> n) | (x << (32 - n));
            return {v[31], v};
        end
        n = r.rsh ? int'(r.rs) : int'(r.so[11:7]);
        if (n == 0) begin
            if (r.rsh || ty == 2'd0) return {r.cin, r.rm};
            if (ty == 2'd3) return {r.rm[0], r.cin, r.rm[31:1]};
            n = 32;
        end
        case (ty)
            2'd0: begin
                if (n < 32) begin
                    w = {32'h0, r.rm} << n; v = w[31:0]; c = w[32];
                end else begin
                    v = 32'h0; c = (n == 32) ? r.rm[0] : 1'b0;
                end
            end
            2'd1: begin
                if (n < 32) begin
                    w = {r.rm, 32'h0} >> n; v = w[63:32]; c = w[31];
                end else begin
                    v = 32'h0; c = (n == 32) ? r.rm[31] : 1'b0;
                end
            end
            2'd2: begin
                if (n < 32) begin
                    sw = $signed({r.rm, 32'h0}) >>> n; v = sw[63:32]; c = sw[31];
                end else begin
                    v = {32{r.rm[31]}}; c = r.rm[31];
                end
            end
            default: begin
                m = n % 32;
                if (m == 0) begin
                    v = r.rm; c = r.rm[31];
                end else begin
                    v = (r.rm >> m) | (r.rm << (32 - m)); c = v[31];
                end
            end
        endcase
        return {c, v};
    endfunction

    function automatic req_t mk(input logic [11:0] so, input logic [31:0] rm, input logic [7:0] rs,
                                input logic imm, input logic mem, input logic rsh,
                                input logic cin, input logic [3:0] tag);
        req_t r;
        r.so = so; r.rm = rm; r.rs = rs; r.imm = imm; r.mem = mem; r.rsh = rsh;
        r.cin = cin; r.tag = tag;
        return r;
    endfunction

    function automatic req_t rnd_req(input logic [3:0] tag);
        req_t r;
        r.so  = 12'($urandom);
        r.rm  = $urandom;
        case ($urandom_range(0, 7))
            0:       r.rs = 8'd0;
            1:       r.rs = 8'd32;
            2:       r.rs = 8'd33;
            3:       r.rs = 8'd31;
            4:       r.rs = 8'd64;
            5:       r.rs = 8'd1;
            default: r.rs = 8'($urandom);
        endcase
        if ($urandom_range(0, 3) == 0) r.so[11:7] = 5'd0;
        r.mem = ($urandom_range(0, 5) == 0);
        r.imm = ($urandom_range(0, 3) == 0);
        r.rsh = 1'($urandom_range(0, 1));
        r.cin = 1'($urandom_range(0, 1));
        r.tag = tag;
        return r;
    endfunction

    // Per-cycle compare: expected handshake and data derived from the in-flight queue.
    always @(negedge clk) begin
        logic exp_ov;
        logic exp_ir;
        req_t cur;
        logic [32:0] res;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
            exp_ir = !flush && ((q.size() < 2) || bus.out_ready);
            chk("out_valid", {63'h0, bus.out_valid}, {63'h0, exp_ov});
            chk("in_ready", {63'h0, bus.in_ready}, {63'h0, exp_ir});
            if (exp_ov) begin
                chk("val2", {32'h0, bus.val2}, {32'h0, q[0].v});
                chk("carry_out", {63'h0, bus.carry_out}, {63'h0, q[0].c});
                chk("out_tag", {60'h0, bus.out_tag}, {60'h0, q[0].tag});
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && exp_ir) begin
                cur = mk(bus.shift_operand, bus.rm_value, bus.rs_value, bus.imm, bus.mem,
                         bus.reg_shift, bus.carry_in, bus.in_tag);
                res   = model(cur);
                e.v   = res[31:0];
                e.c   = res[32];
                e.tag = cur.tag;
                e.cyc = cyc;
                q.push_back(e);
            end
            if (flush) q.delete();
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic drive(input req_t r);
        bus.shift_operand = r.so;
        bus.rm_value      = r.rm;
        bus.rs_value      = r.rs;
        bus.imm           = r.imm;
        bus.mem           = r.mem;
        bus.reg_shift     = r.rsh;
        bus.carry_in      = r.cin;
        bus.in_tag        = r.tag;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input req_t r);
        int unsigned budget;
        logic        done;
        budget = 0;
        done   = 1'b0;
        drive(r);
        bus.in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) begin
                budget++;
                if (budget > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL send_timeout: got no in_ready expected acceptance within 200 cycles");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", q.size());
        end
    endtask

    task automatic idle(input int unsigned n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        req_t r;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(mk(12'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0));

        // Pin the reference model to hand-derived results.
        chk("pin_imm_rot", {31'h0, model(mk(12'h4FF, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0))}, {31'h0, 33'h1_FF000000});
        chk("pin_lsr32", {31'h0, model(mk(12'h020, 32'h80000001, 8'd32, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0))}, {31'h0, 33'h1_00000000});
        chk("pin_lsr33", {31'h0, model(mk(12'h020, 32'h80000001, 8'd33, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0))}, {31'h0, 33'h0_00000000});
        chk("pin_rrx", {31'h0, model(mk(12'h060, 32'h00000003, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0))}, {31'h0, 33'h1_80000001});
        chk("pin_mem", {31'h0, model(mk(12'hFFC, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0))}, {31'h0, 33'h0_FFFFFFFC});
        chk("pin_lsl4", {31'h0, model(mk(12'h200, 32'hF0000001, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0))}, {31'h0, 33'h1_00000010});
        chk("pin_asr40", {31'h0, model(mk(12'h040, 32'h80000000, 8'd40, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0))}, {31'h0, 33'h1_FFFFFFFF});
        chk("pin_ror64", {31'h0, model(mk(12'h060, 32'h12345678, 8'd64, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0))}, {31'h0, 33'h0_12345678});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_val2", {32'h0, bus.val2}, 64'h0);
        chk("rst_carry", {63'h0, bus.carry_out}, 64'h0);
        chk("rst_tag", {60'h0, bus.out_tag}, 64'h0);
        @(posedge clk);
        #1;

        // Latency: accepted cycle c, out_valid visible in cycle c+2.
        send(mk(12'h4FF, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1));
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_c1", {63'h0, bus.out_valid}, 64'h0);
        @(negedge clk);
        chk("lat_c2", {63'h0, bus.out_valid}, 64'h1);
        chk("lat_val2", {32'h0, bus.val2}, 64'hFF000000);
        @(posedge clk);
        #1;

        send(mk(12'h020, 32'h80000001, 8'd32, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2));
        send(mk(12'h020, 32'h80000001, 8'd33, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3));
        send(mk(12'h060, 32'h00000003, 8'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4));
        send(mk(12'hFFC, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5));
        send(mk(12'h200, 32'hF0000001, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6));
        drain();

        rdy_rand = 1'b1;
        for (int i = 0; i < 8; i++) send(rnd_req(4'(i)));
        for (int i = 0; i < 300; i++) begin
            send(rnd_req(4'($urandom)));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        rdy_rand = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Flush with both stages occupied and a request offered in the flush cycle.
        bus.out_ready = 1'b0;
        send(rnd_req(4'hA));
        send(rnd_req(4'hB));
        r = rnd_req(4'hC);
        drive(r);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("flush_ov", {63'h0, bus.out_valid}, 64'h0);
        idle(5);

        // Asynchronous reset with work in flight.
        bus.out_ready = 1'b0;
        send(rnd_req(4'hD));
        send(rnd_req(4'hE));
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_rst_ov", {63'h0, bus.out_valid}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_val2", {32'h0, bus.val2}, 64'h0);
        chk("rst2_tag", {60'h0, bus.out_tag}, 64'h0);
        @(posedge clk);
        #1;
        idle(5);
        send(mk(12'h060, 32'h12345678, 8'd64, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7));
        drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/val2_pipe_shifter.md
# val2_pipe_shifter

Pipelined, parametrised successor of the operand-2 (Val2) generator in the execute stage. It computes the second ALU operand for these operand classes:

- rotated 8-bit immediate;
- register shifted by an immediate;
- register shifted by a register amount (new);
- sign-extended memory offset.

It adds a shifter carry-out, RRX and valid/ready flow control. It sits between ID/EX operand fetch and the ALU. Per-transaction tags are returned in order.

## Interface
Parameters:
- DATA_W, 32, operand width; power of two, ≥ 16
- TAG_W, 4, width of opaque tag carried with each transaction

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all in-flight transactions
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- shift_operand  in  12  immediate/shift field: [7:0] imm8, [11:8] rot, [11:7] shift_imm, [6:5] shift type, [11:8] Rs index (unused here)
- rm_value  in  DATA_W  Rm operand
- rs_value  in  8  low byte of Rs (register shift amount)
- imm  in  1  immediate-rotate mode
- mem  in  1  memory-offset mode (priority over imm)
- reg_shift  in  1  shift amount from rs_value instead of shift_imm
- carry_in  in  1  current C flag
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- val2  out  DATA_W  operand 2
- carry_out  out  1  shifter carry
- out_tag  out  TAG_W  tag of the current result

## Operation
- Priority: mem > imm > register shift.
- mem: val2 = shift_operand sign-extended to DATA_W; carry_out = carry_in.
- imm: val2 = zero-extended imm8 rotated right by 2*rot within DATA_W.
  - carry_out = carry_in if rot==0, else val2[DATA_W-1].
- Shift types: LSL=00, LSR=01, ASR=10, ROR=11.
- Immediate amount (reg_shift=0), n = shift_imm:
  - LSL #0: val2 = Rm, carry = carry_in.
  - LSR #0 / ASR #0 encode a shift by DATA_W.
  - ROR #0 is RRX: val2 = {carry_in, Rm[DATA_W-1:1]}, carry = Rm[0].
- Register amount (reg_shift=1), n = rs_value:
  - n==0: val2 = Rm, carry = carry_in (all types).
  - LSL/LSR with n==DATA_W: val2 = 0; carry = Rm[0] (LSL) or Rm[DATA_W-1] (LSR).
  - LSL/LSR with n>DATA_W: val2 = 0, carry = 0.
  - ASR with n≥DATA_W: val2 = all Rm[DATA_W-1]; carry = Rm[DATA_W-1].
  - ROR: effective amount = n mod DATA_W. If that is 0 (n≠0): val2 = Rm, carry = Rm[DATA_W-1].
- Normal shifts (0<n<DATA_W): carry = last bit shifted out.

## Timing
- Two register stages.
  - S1 captures the request and the decoded mode/type/effective amount/special-case flags.
  - S2 captures val2, carry_out, out_tag.
- Latency: 2 cycles from acceptance to out_valid. Throughput: 1 per cycle while out_ready=1.
- Handshake:
  - S2 advances when !out_valid | out_ready.
  - in_ready = !s1_valid | S2 advances. in_ready is combinational on out_ready.
- While out_valid=1 & out_ready=0, val2/carry_out/out_tag hold stable.
- Results emerge in acceptance order. No drops except on flush.
- flush: next edge clears s1_valid and out_valid. Any input offered in the flush cycle is not accepted (in_ready=0 while flush=1). Data registers keep their values.
- Reset (async assert, sync-released use) sets:
  - s1_valid=0, out_valid=0;
  - val2=0, carry_out=0, out_tag=0.
  - in_ready=1 in the first cycle after release.
- Reset mid-transfer: all in-flight work is lost; no output after release until new input.

## Structure
- Package val2_pkg holds:
  - shift-type enum (LSL/LSR/ASR/ROR);
  - mode enum (MEM/IMM/SHIFT_IMM/SHIFT_REG);
  - S1 payload struct.
- Sub-module val2_shift_core: combinational, parametrised by DATA_W.
  - Inputs: Rm, type, effective amount, special flags, carry_in.
  - Outputs: result and carry.
  - Instantiated between S1 and S2.
- Pipeline/handshake control stays in the top module.

## Test plan
- imm=1, shift_operand=0x4FF, carry_in=0 -> val2=0xFF000000, carry_out=1, out_valid exactly 2 cycles after acceptance.
- reg_shift=1, LSR, rs_value=32, Rm=0x80000001 -> val2=0, carry_out=1. Repeat with rs_value=33 -> val2=0, carry_out=0.
- ROR #0 immediate (RRX), Rm=0x00000003, carry_in=1 -> val2=0x80000001, carry_out=1.
- mem=1 and imm=1, shift_operand=0xFFC -> val2=0xFFFFFFFC (mem priority).
- Back-to-back stream, tags 0..7, out_ready toggled randomly -> all 8 results in order, outputs stable while stalled, no duplicates.
- flush asserted with both stages full, and separately async reset mid-stream -> out_valid=0 next cycle, no stale result delivered afterwards.
